// File: rtl/ahb_mem_target_pkg.sv
// Shared types and constants for the AHB memory target: FSM encoding,
// wait-counter width and the byte-to-word address offset.
package ahb_mem_target_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int CNT_W    = 4;
    localparam int WORD_OFF = 2;

    // IDX_W = $clog2(DEPTH); DEPTH is a module parameter, so it is derived here
    function automatic int idx_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/ahb_mem_target_sram.sv
// Single-port DEPTH x DATA_WIDTH storage with synchronous write and a
// registered read port that only updates when a read is issued.
module ahb_mem_target_sram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int IDX_W      = 8
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [IDX_W-1:0]      i_idx,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ahb_mem_target.sv
// Word-addressed SRAM target behind the AHB slave, with programmable wait
// states and an out-of-range error strobe.
module ahb_mem_target
    import ahb_mem_target_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR        = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  i_clk_ahb,
    input  logic                  i_rstn_ahb,
    input  logic                  i_valid,
    input  logic                  i_rd0_wr1,
    input  logic [ADDR-1:0]       i_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_ready,
    output logic                  o_rd_valid,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_err
);

    localparam int IDX_W = idx_width(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES - 1);

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_ready;
    logic                  r_rd_valid;
    logic                  r_err;
    logic                  r_zero;

    logic                  r_dir;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_inr;

    logic                  w_accept;
    logic                  w_inr;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_fire_now;
    logic                  w_fire_late;
    logic                  w_exec;
    logic                  w_ex_wr;
    logic                  w_ex_inr;
    logic [IDX_W-1:0]      w_ex_idx;
    logic [DATA_WIDTH-1:0] w_ex_data;
    logic [DATA_WIDTH-1:0] w_sram_q;

    // In range when every address bit above the word index is zero
    assign w_idx    = i_addr[WORD_OFF +: IDX_W];
    assign w_inr    = ((i_addr >> (WORD_OFF + IDX_W)) == '0);
    assign w_accept = i_valid && r_ready;

    // Zero wait states execute the live request; otherwise the captured one
    assign w_fire_now  = w_accept && (WAIT_STATES == 0);
    assign w_fire_late = (r_state == ST_BUSY) && (r_cnt == '0);
    assign w_exec      = w_fire_now || w_fire_late;
    assign w_ex_wr     = w_fire_late ? r_dir   : i_rd0_wr1;
    assign w_ex_inr    = w_fire_late ? r_inr   : w_inr;
    assign w_ex_idx    = w_fire_late ? r_idx   : w_idx;
    assign w_ex_data   = w_fire_late ? r_wdata : i_wr_data;

    always_ff @(posedge i_clk_ahb) begin
        if (w_accept) begin
            r_dir   <= i_rd0_wr1;
            r_idx   <= w_idx;
            r_wdata <= i_wr_data;
            r_inr   <= w_inr;
        end
    end

    always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
        if (!i_rstn_ahb) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_ready    <= 1'b1;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
            r_zero     <= 1'b1;
        end else begin
            r_rd_valid <= w_exec && !w_ex_wr;
            r_err      <= w_exec && !w_ex_inr;
            // r_zero forces the read bus to 0 until an in-range read lands
            if (w_exec && !w_ex_wr) begin
                r_zero <= !w_ex_inr;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && (WAIT_STATES != 0)) begin
                        r_state <= ST_BUSY;
                        r_cnt   <= CNT_LOAD;
                        r_ready <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    ahb_mem_target_sram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_sram (
        .i_clk   (i_clk_ahb),
        .i_we    (w_exec && w_ex_wr && w_ex_inr),
        .i_re    (w_exec && !w_ex_wr && w_ex_inr),
        .i_idx   (w_ex_idx),
        .i_wdata (w_ex_data),
        .o_rdata (w_sram_q)
    );

    assign o_ready    = r_ready;
    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_zero ? '0 : w_sram_q;
    assign o_err      = r_err;

endmodule

// File: tb/tb_ahb_mem_target.sv
// Directed bench for ahb_mem_target: three instances with 0, 3 and 2 wait
// states share the request bus and reset, each with its own i_valid.
module tb_ahb_mem_target;

    logic        clk;
    logic        rstn;
    logic        dir;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        v0, v3, v2;
    logic        rdy0, rv0, err0;
    logic        rdy3, rv3, err3;
    logic        rdy2, rv2, err2;
    logic [31:0] rd0, rd3, rd2;

    int passed = 0;
    int total  = 0;

    ahb_mem_target #(.DATA_WIDTH(32), .ADDR(32), .DEPTH(256), .WAIT_STATES(0)) u_w0 (
        .i_clk_ahb(clk), .i_rstn_ahb(rstn), .i_valid(v0), .i_rd0_wr1(dir),
        .i_addr(addr), .i_wr_data(wd), .o_ready(rdy0), .o_rd_valid(rv0),
        .o_rd_data(rd0), .o_err(err0));

    ahb_mem_target #(.DATA_WIDTH(32), .ADDR(32), .DEPTH(256), .WAIT_STATES(3)) u_w3 (
        .i_clk_ahb(clk), .i_rstn_ahb(rstn), .i_valid(v3), .i_rd0_wr1(dir),
        .i_addr(addr), .i_wr_data(wd), .o_ready(rdy3), .o_rd_valid(rv3),
        .o_rd_data(rd3), .o_err(err3));

    ahb_mem_target #(.DATA_WIDTH(32), .ADDR(32), .DEPTH(256), .WAIT_STATES(2)) u_w2 (
        .i_clk_ahb(clk), .i_rstn_ahb(rstn), .i_valid(v2), .i_rd0_wr1(dir),
        .i_addr(addr), .i_wr_data(wd), .o_ready(rdy2), .o_rd_valid(rv2),
        .o_rd_data(rd2), .o_err(err2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Issue one request on a wait-state instance (2 or 3) and wait, bounded,
    // until it has completed; reads return the strobed data.
    task automatic slow_op(input int which, input logic d, input logic [31:0] a,
                           input logic [31:0] w, output logic [31:0] rdat,
                           output logic done);
        logic got;
        dir = d; addr = a; wd = w;
        if (which == 3) v3 = 1'b1; else v2 = 1'b1;
        tick();
        v3 = 1'b0; v2 = 1'b0;
        done = 1'b0; got = 1'b0; rdat = '0;
        for (int i = 0; i < 20 && !done; i++) begin
            if ((which == 3) ? rv3 : rv2) begin
                rdat = (which == 3) ? rd3 : rd2;
                got  = 1'b1;
            end
            if (((which == 3) ? rdy3 : rdy2) && (d || got)) done = 1'b1;
            else tick();
        end
    endtask

    logic [31:0] r;
    logic        ok;

    initial begin
        rstn = 1'b0; dir = 1'b0; addr = '0; wd = '0;
        v0 = 1'b0; v3 = 1'b0; v2 = 1'b0;
        tick(); tick();
        chk("rst_ready", {29'd0, rdy0, rdy3, rdy2}, 32'h7);
        chk("rst_rdvalid", {29'd0, rv0, rv3, rv2}, 32'h0);
        chk("rst_err", {29'd0, err0, err3, err2}, 32'h0);
        chk("rst_rddata0", rd0, 32'h0);
        rstn = 1'b1;
        tick();

        // 1: write then read, zero wait states
        dir = 1'b1; addr = 32'hA; wd = 32'hAAAA_AAAA; v0 = 1'b1;
        tick();
        chk("t1_ready_after_wr", {31'd0, rdy0}, 32'h1);
        chk("t1_no_rv_after_wr", {31'd0, rv0}, 32'h0);
        dir = 1'b0;
        tick();
        v0 = 1'b0;
        chk("t1_rv", {31'd0, rv0}, 32'h1);
        chk("t1_data", rd0, 32'hAAAA_AAAA);
        chk("t1_ready", {31'd0, rdy0}, 32'h1);
        tick();
        chk("t1_rv_drop", {31'd0, rv0}, 32'h0);
        chk("t1_data_hold", rd0, 32'hAAAA_AAAA);

        // 2: back-to-back writes then reads
        dir = 1'b1; addr = 32'h4; wd = 32'h1111_1111; v0 = 1'b1;
        tick();
        addr = 32'h8; wd = 32'h2222_2222;
        tick();
        dir = 1'b0; addr = 32'h4;
        tick();
        chk("t2_rv_a", {31'd0, rv0}, 32'h1);
        chk("t2_data_a", rd0, 32'h1111_1111);
        addr = 32'h8;
        tick();
        v0 = 1'b0;
        chk("t2_rv_b", {31'd0, rv0}, 32'h1);
        chk("t2_data_b", rd0, 32'h2222_2222);
        tick();
        chk("t2_rv_end", {31'd0, rv0}, 32'h0);

        // 4: out-of-range write and read alias onto idx 0 but must not touch it
        dir = 1'b1; addr = 32'h0; wd = 32'h0BAD_0000; v0 = 1'b1;
        tick();
        addr = 32'h400; wd = 32'h5555_5555;
        tick();
        chk("t4_err_wr", {31'd0, err0}, 32'h1);
        chk("t4_rv_wr", {31'd0, rv0}, 32'h0);
        dir = 1'b0; addr = 32'h400;
        tick();
        chk("t4_err_rd", {31'd0, err0}, 32'h1);
        chk("t4_rv_rd", {31'd0, rv0}, 32'h1);
        chk("t4_data_rd", rd0, 32'h0);
        addr = 32'h0;
        tick();
        v0 = 1'b0;
        chk("t4_err_clear", {31'd0, err0}, 32'h0);
        chk("t4_mem0", rd0, 32'h0BAD_0000);
        tick();

        // 3: three wait states
        dir = 1'b1; addr = 32'hC; wd = 32'hDDDD_DDDD; v3 = 1'b1;
        tick();
        v3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t3_wr_busy%0d", i), {31'd0, rdy3}, 32'h0);
            tick();
        end
        chk("t3_wr_ready", {31'd0, rdy3}, 32'h1);
        dir = 1'b0; v3 = 1'b1;
        tick();
        v3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t3_rd_busy%0d", i), {30'd0, rdy3, rv3}, 32'h0);
            tick();
        end
        chk("t3_rd_ready", {31'd0, rdy3}, 32'h1);
        chk("t3_rv", {31'd0, rv3}, 32'h1);
        chk("t3_data", rd3, 32'hDDDD_DDDD);
        tick();
        chk("t3_rv_drop", {31'd0, rv3}, 32'h0);

        // 5: reset during BUSY discards a pending write
        slow_op(3, 1'b1, 32'h10, 32'h1234, r, ok);
        chk("t5_preload_done", {31'd0, ok}, 32'h1);
        dir = 1'b1; addr = 32'h10; wd = 32'hBEEF; v3 = 1'b1;
        tick();
        v3 = 1'b0;
        chk("t5_busy", {31'd0, rdy3}, 32'h0);
        rstn = 1'b0;
        #1;
        chk("t5_rst_ready", {31'd0, rdy3}, 32'h1);
        chk("t5_rst_rv", {31'd0, rv3}, 32'h0);
        chk("t5_rst_data", rd3, 32'h0);
        tick();
        rstn = 1'b1;
        tick();
        slow_op(3, 1'b0, 32'h10, 32'h0, r, ok);
        chk("t5_read_done", {31'd0, ok}, 32'h1);
        chk("t5_data", r, 32'h1234);

        // 6: i_valid held high with changing address during BUSY
        slow_op(2, 1'b1, 32'h18, 32'hC0DE_0018, r, ok);
        chk("t6_pre18", {31'd0, ok}, 32'h1);
        slow_op(2, 1'b1, 32'h1C, 32'hC0DE_001C, r, ok);
        chk("t6_pre1c", {31'd0, ok}, 32'h1);
        dir = 1'b1; addr = 32'h14; wd = 32'h66; v2 = 1'b1;
        tick();
        chk("t6_busy0", {31'd0, rdy2}, 32'h0);
        addr = 32'h18; wd = 32'h77;
        tick();
        chk("t6_busy1", {31'd0, rdy2}, 32'h0);
        addr = 32'h1C; wd = 32'h88;
        tick();
        chk("t6_ready", {31'd0, rdy2}, 32'h1);
        chk("t6_no_err", {31'd0, err2}, 32'h0);
        v2 = 1'b0;
        tick();
        chk("t6_stay_ready", {31'd0, rdy2}, 32'h1);
        slow_op(2, 1'b0, 32'h14, 32'h0, r, ok);
        chk("t6_rd14", r, 32'h66);
        slow_op(2, 1'b0, 32'h18, 32'h0, r, ok);
        chk("t6_rd18", r, 32'hC0DE_0018);
        slow_op(2, 1'b0, 32'h1C, 32'h0, r, ok);
        chk("t6_rd1c", r, 32'hC0DE_001C);
        chk("t6_rd_done", {31'd0, ok}, 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ahb_mem_target.md
Name: ahb_mem_target

Overview:
- Word-addressed SRAM target on the memory side of the AHB slave (AHB_slave).
- Consumes the slave's o_valid/o_rd0_wr1/o_addr/o_wr_data request.
- Returns i_ready/i_rd_valid/i_rd_data to the slave.
- Programmable wait states model slow memory and exercise the slave's HREADYOUT stretching.
- Out-of-range accesses are flagged on o_err.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR, 32, address bus width.
- DEPTH, 256, number of words; power of two, at least 2.
- WAIT_STATES, 0, cycles o_ready is held low after each accepted request; 0 to 15.

Ports:
- i_clk_ahb  in  1  clock.
- i_rstn_ahb  in  1  asynchronous active-low reset.
- i_valid  in  1  request valid (from slave o_valid).
- i_rd0_wr1  in  1  0 = read, 1 = write.
- i_addr  in  ADDR  byte address.
- i_wr_data  in  DATA_WIDTH  write data.
- o_ready  out  1  target can accept a request (to slave i_ready).
- o_rd_valid  out  1  one-cycle read-data strobe (to slave i_rd_valid).
- o_rd_data  out  DATA_WIDTH  read data (to slave i_rd_data).
- o_err  out  1  one-cycle out-of-range strobe.

Behaviour:
- Reset (async, active-low):
  - o_ready=1, o_rd_valid=0, o_rd_data=0, o_err=0.
  - State=IDLE, wait counter=0.
  - Memory contents are not reset.
- Index and range:
  - idx = i_addr[2 +: log2(DEPTH)]; i_addr[1:0] ignored.
  - In range iff i_addr[ADDR-1:2] < DEPTH.
- Accept: a rising edge with i_valid=1 and o_ready=1. The request (dir, idx, data, range flag) is captured into internal registers at that edge.
- FSM states: IDLE, BUSY.
- IDLE: o_ready=1.
  - Accept with WAIT_STATES=0: execute at the same edge, stay IDLE.
  - Accept with WAIT_STATES>0: load counter=WAIT_STATES-1, go to BUSY.
- BUSY: o_ready=0.
  - Counter decrements each cycle.
  - At the edge where counter=0: execute the captured request, go to IDLE.
  - i_valid is ignored while in BUSY.
- Execute, write in range: mem[idx] <= wr_data.
- Execute, read in range: o_rd_data <= mem[idx], and o_rd_valid=1 for exactly the next cycle.
- Execute, out of range:
  - Write: dropped.
  - Read: o_rd_data <= 0, o_rd_valid=1 for one cycle.
  - Either case: o_err=1 for one cycle, aligned with where o_rd_valid would be.
- Latency: accept edge to o_rd_valid high = WAIT_STATES+1 cycles. A write is visible to a read accepted on the following edge.
- Back-to-back with WAIT_STATES=0:
  - One request per cycle.
  - o_rd_valid may stay high across consecutive reads, with new data each cycle.
- o_rd_data holds its last value between strobes.
- Read-after-write to the same index on consecutive accepts returns the new data; no bypass is needed because the write commits at the earlier edge.
- Reset asserted mid-BUSY: returns to IDLE immediately, the pending request is discarded, no memory write occurs.

Decomposition:
- Package ahb_mem_target_pkg holds:
  - State encoding (IDLE=1'b0, BUSY=1'b1).
  - Localparams: IDX_W = $clog2(DEPTH), CNT_W = 4, word offset 2.
- Sub-module ahb_mem_target_sram holds the storage:
  - Ports: single port, synchronous write enable, synchronous registered read, DEPTH x DATA_WIDTH.
  - The FSM and counter stay in the top module.

Test Plan:
1. WAIT_STATES=0. Write 0xAAAA_AAAA to 0xA, then read 0xA next cycle.
   -> o_ready stays 1; o_rd_valid high one cycle after the read accept; o_rd_data=0xAAAA_AAAA.
2. WAIT_STATES=0. Write 0x1111_1111 to 0x4 and 0x2222_2222 to 0x8, then back-to-back reads of 0x4 and 0x8.
   -> o_rd_valid high for 2 consecutive cycles carrying 0x1111_1111 then 0x2222_2222.
3. WAIT_STATES=3. Write 0xDDDD_DDDD to 0xC, then read 0xC.
   -> o_ready low for exactly 3 cycles after each accept; o_rd_valid 4 cycles after the read accept; data=0xDDDD_DDDD.
4. DEPTH=256. Write 0x5555_5555 to 0x400, then read 0x400.
   -> o_err pulses once for each access; read returns 0; mem[0] is unchanged (read 0x0 returns its prior value).
5. WAIT_STATES=3. Accept write 0xBEEF to 0x10, deassert i_rstn_ahb during BUSY, release, then read 0x10.
   -> o_ready=1 and o_rd_valid=0 immediately on reset; the read does not return 0xBEEF (pre-load 0x10 with 0x1234 and expect 0x1234).
6. WAIT_STATES=2. Hold i_valid=1 with changing address during BUSY.
   -> only the request captured at accept executes; no extra accepts until o_ready returns to 1.
